// File: rtl/uart_tx_scheduler_pkg.sv
// Shared definitions for the buffered UART transmit scheduler.
package uart_tx_scheduler_pkg;

  // Transmit sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESENT = 2'd1,
    ST_GAP     = 2'd2
  } tx_state_e;

  // IO page bit indices: the existing GPIO/UART bits and the new queue words.
  localparam int unsigned IO_GPIO_BIT       = 0;
  localparam int unsigned IO_UART_BIT       = 1;
  localparam int unsigned IO_TXQ_DATA_BIT   = 2;
  localparam int unsigned IO_TXQ_STATUS_BIT = 3;

  // Bit positions inside the transmit queue status word.
  localparam int unsigned TXQ_STAT_EMPTY     = 0;
  localparam int unsigned TXQ_STAT_FULL      = 1;
  localparam int unsigned TXQ_STAT_BUSY      = 2;
  localparam int unsigned TXQ_STAT_OVERFLOW  = 3;
  localparam int unsigned TXQ_STAT_LEVEL_LSB = 8;

endpackage

// File: rtl/uart_tx_scheduler_fifo.sv
// Byte-wide synchronous FIFO with a separate occupancy counter and single-cycle flush.
module sync_fifo_byte #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          rd_en,
  input  logic          flush,
  output logic [7:0]    rd_data,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty
);

  localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

  logic [7:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   level_r;
  logic          push_s;
  logic          pop_s;

  // A flush drops a concurrent write; writes when full and pops when empty are ignored.
  assign push_s = wr_en & ~full & ~flush;
  assign pop_s  = rd_en & ~empty;

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointer and level bookkeeping; flush empties the queue after any same-cycle pop reads out.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + 1'b1;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + 1'b1;
        2'b01:   level_r <= level_r - 1'b1;
        default: level_r <= level_r;
      endcase
    end
  end

  assign rd_data = mem_r[rd_ptr_r];
  assign level   = level_r;
  assign full    = (level_r == DEPTH_L);
  assign empty   = (level_r == '0);

endmodule

// File: rtl/uart_tx_scheduler.sv
// Buffered UART transmit scheduler: queues bus byte writes and hands them to the emitter.
module uart_tx_scheduler
  import uart_tx_scheduler_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_wr,
  input  logic [7:0]    i_wdata,
  input  logic          i_flush,
  input  logic          i_clr_ovf,
  output logic [7:0]    o_data,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [AW:0]   o_level,
  output logic          o_full,
  output logic          o_empty,
  output logic          o_busy,
  output logic          o_overflow
);

  tx_state_e   state_r;
  tx_state_e   state_s;
  logic [7:0]  data_r;
  logic        valid_r;
  logic        ovf_r;
  logic        pop_s;
  logic        ovf_set_s;
  logic [7:0]  fifo_rdata_s;
  logic [AW:0] fifo_level_s;
  logic        fifo_full_s;
  logic        fifo_empty_s;

  sync_fifo_byte #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk     (i_clk),
    .rst     (i_rst),
    .wr_en   (i_wr),
    .wr_data (i_wdata),
    .rd_en   (pop_s),
    .flush   (i_flush),
    .rd_data (fifo_rdata_s),
    .level   (fifo_level_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s)
  );

  // Sequencer state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state and pop decision: pop in IDLE, hold in PRESENT until ready, one dead GAP cycle.
  always_comb begin
    state_s = state_r;
    pop_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!fifo_empty_s) begin
          pop_s   = 1'b1;
          state_s = ST_PRESENT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_PRESENT: begin
        if (i_ready) begin
          state_s = ST_GAP;
        end else begin
          state_s = ST_PRESENT;
        end
      end
      ST_GAP: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Emitter-facing registers: valid follows the next state, data is loaded only on a pop.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_r <= 1'b0;
      data_r  <= 8'h00;
    end else begin
      valid_r <= (state_s == ST_PRESENT);
      if (pop_s) begin
        data_r <= fifo_rdata_s;
      end
    end
  end

  // A write is lost only when the queue was full at cycle start and no flush claims it.
  assign ovf_set_s = i_wr & fifo_full_s & ~i_flush;

  // Sticky overflow flag; a new drop wins over a same-cycle clear.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ovf_r <= 1'b0;
    end else if (ovf_set_s) begin
      ovf_r <= 1'b1;
    end else if (i_clr_ovf) begin
      ovf_r <= 1'b0;
    end else begin
      ovf_r <= ovf_r;
    end
  end

  assign o_data     = data_r;
  assign o_valid    = valid_r;
  assign o_level    = fifo_level_s;
  assign o_full     = fifo_full_s;
  assign o_empty    = fifo_empty_s;
  assign o_overflow = ovf_r;
  assign o_busy     = ~fifo_empty_s | (state_r != ST_IDLE) | ~i_ready;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler against a queue-based reference model.
module tb_uart_tx_scheduler;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr;
  logic [7:0]  wdata;
  logic        flush;
  logic        clr_ovf;
  logic        ready;
  logic [7:0]  o_data;
  logic        o_valid;
  logic [AW:0] o_level;
  logic        o_full;
  logic        o_empty;
  logic        o_busy;
  logic        o_overflow;

  always #5 clk = ~clk;

  uart_tx_scheduler #(.DEPTH(DEPTH), .AW(AW)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_wr       (wr),
    .i_wdata    (wdata),
    .i_flush    (flush),
    .i_clr_ovf  (clr_ovf),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .i_ready    (ready),
    .o_level    (o_level),
    .o_full     (o_full),
    .o_empty    (o_empty),
    .o_busy     (o_busy),
    .o_overflow (o_overflow)
  );

  int checks = 0;
  int errors = 0;
  int max_lvl = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a byte queue, the held byte, and the cycle of the last handshake.
  logic [7:0] m_q[$];
  logic [7:0] m_held = 8'h00;
  bit         m_pres = 1'b0;
  bit         m_ovf = 1'b0;
  bit         m_ok = 1'b0;
  int         m_cyc = 0;
  int         m_last_hs = -100;

  always @(posedge clk) begin
    bit full_pre;
    bit free;
    bit pop;
    bit hs;
    if (rst) begin
      m_q.delete();
      m_held    = 8'h00;
      m_pres    = 1'b0;
      m_ovf     = 1'b0;
      m_last_hs = -100;
      m_ok      = 1'b1;
    end else begin
      full_pre = (m_q.size() == DEPTH);
      // Presenter takes a new byte only when nothing is shown and the post-handshake gap is over.
      free = !m_pres && (m_cyc >= m_last_hs + 2);
      pop  = free && (m_q.size() != 0);
      hs   = m_pres && ready;
      if (hs) begin
        m_pres    = 1'b0;
        m_last_hs = m_cyc;
      end
      if (pop) begin
        m_held = m_q.pop_front();
        m_pres = 1'b1;
      end
      if (wr && full_pre && !flush) m_ovf = 1'b1;
      else if (clr_ovf) m_ovf = 1'b0;
      if (wr && !full_pre && !flush) m_q.push_back(wdata);
      if (flush) m_q.delete();
    end
    m_cyc++;
  end

  // Record completed handshakes as seen on the DUT interface.
  logic [7:0] got[$];
  always @(posedge clk) begin
    if (!rst && o_valid && ready) got.push_back(o_data);
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (m_ok) begin
      check("o_valid", 32'(o_valid), 32'(m_pres));
      check("o_data", 32'(o_data), 32'(m_held));
      check("o_level", 32'(o_level), 32'(m_q.size()));
      check("o_full", 32'(o_full), 32'(m_q.size() == DEPTH));
      check("o_empty", 32'(o_empty), 32'(m_q.size() == 0));
      check("o_overflow", 32'(o_overflow), 32'(m_ovf));
      check("o_busy", 32'(o_busy),
            32'((m_q.size() != 0) || m_pres || (m_cyc == m_last_hs + 1) || !ready));
      if (int'(o_level) > max_lvl) max_lvl = int'(o_level);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write_byte(input logic [7:0] b);
    wr    = 1'b1;
    wdata = b;
    tick(1);
    wr    = 1'b0;
  endtask

  task automatic drain(input int budget, input bit rand_ready);
    int n;
    n = 0;
    while (!(o_empty && !o_valid) && n < budget) begin
      ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      tick(1);
      n++;
    end
    check("drain_in_budget", 32'(n < budget), 32'd1);
  endtask

  initial begin
    int w;
    rst = 1'b1; wr = 1'b0; wdata = 8'h00; flush = 1'b0; clr_ovf = 1'b0; ready = 1'b1;
    tick(3);
    rst = 1'b0;
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_empty", 32'(o_empty), 32'd1);
    check("rst_full", 32'(o_full), 32'd0);
    check("rst_level", 32'(o_level), 32'd0);
    check("rst_data", 32'(o_data), 32'd0);
    check("rst_ovf", 32'(o_overflow), 32'd0);
    tick(5);

    // Single byte with ready held high.
    write_byte(8'h41);
    check("single_level_n1", 32'(o_level), 32'd1);
    check("single_valid_n1", 32'(o_valid), 32'd0);
    tick(1);
    check("single_valid_n2", 32'(o_valid), 32'd1);
    check("single_data_n2", 32'(o_data), 32'h41);
    tick(1);
    check("single_valid_n3", 32'(o_valid), 32'd0);
    tick(1);
    check("single_busy_n4", 32'(o_busy), 32'd0);

    // Fill to full with the emitter stalled.
    ready = 1'b0;
    for (int k = 0; k < 17; k++) write_byte(8'(k));
    check("fill_level", 32'(o_level), 32'd16);
    check("fill_full", 32'(o_full), 32'd1);
    check("fill_ovf", 32'(o_overflow), 32'd0);
    check("fill_valid", 32'(o_valid), 32'd1);
    check("fill_data", 32'(o_data), 32'h00);
    write_byte(8'h11);
    check("overflow_set", 32'(o_overflow), 32'd1);
    check("overflow_level", 32'(o_level), 32'd16);
    clr_ovf = 1'b1;
    tick(1);
    clr_ovf = 1'b0;
    check("overflow_clear", 32'(o_overflow), 32'd0);

    // Ordered drain with a randomly stalling emitter.
    got.delete();
    drain(600, 1'b1);
    check("drain_count", 32'(got.size()), 32'd17);
    for (int i = 0; i < 17 && i < got.size(); i++) check("drain_order", 32'(got[i]), 32'(i));
    check("drain_empty", 32'(o_empty), 32'd1);

    // Wrap-around stream of 40 bytes with random stalls.
    got.delete();
    for (int k = 0; k < 40; k++) begin
      w = 0;
      while (o_full && w < 200) begin
        ready = 1'($urandom_range(0, 1));
        tick(1);
        w++;
      end
      check("stream_wait", 32'(w < 200), 32'd1);
      ready = 1'($urandom_range(0, 1));
      write_byte(8'h80 + 8'(k));
      ready = 1'($urandom_range(0, 1));
      tick($urandom_range(0, 2));
    end
    drain(1000, 1'b1);
    check("stream_count", 32'(got.size()), 32'd40);
    for (int i = 0; i < 40 && i < got.size(); i++) check("stream_order", 32'(got[i]), 32'h80 + 32'(i));
    check("max_level_le_depth", 32'(max_lvl <= DEPTH), 32'd1);
    check("max_level_reached", 32'(max_lvl >= 1), 32'd1);

    // Flush together with a write while one byte is being presented.
    ready = 1'b0;
    for (int k = 0; k < 5; k++) write_byte(8'hA0 + 8'(k));
    check("preflush_level", 32'(o_level), 32'd4);
    flush = 1'b1; wr = 1'b1; wdata = 8'h55;
    tick(1);
    flush = 1'b0; wr = 1'b0;
    check("flush_level", 32'(o_level), 32'd0);
    check("flush_ovf", 32'(o_overflow), 32'd0);
    check("flush_valid_kept", 32'(o_valid), 32'd1);
    check("flush_data_kept", 32'(o_data), 32'hA0);
    got.delete();
    drain(100, 1'b0);
    check("flush_count", 32'(got.size()), 32'd1);
    if (got.size() > 0) check("flush_byte", 32'(got[0]), 32'hA0);

    // Reset while presenting with three bytes queued.
    tick(3);
    ready = 1'b0;
    for (int k = 0; k < 4; k++) write_byte(8'hC0 + 8'(k));
    check("prereset_level", 32'(o_level), 32'd3);
    check("prereset_valid", 32'(o_valid), 32'd1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("midrst_valid", 32'(o_valid), 32'd0);
    check("midrst_level", 32'(o_level), 32'd0);
    check("midrst_ovf", 32'(o_overflow), 32'd0);
    write_byte(8'h33);
    tick(1);
    check("postrst_valid", 32'(o_valid), 32'd1);
    check("postrst_data", 32'(o_data), 32'h33);
    drain(100, 1'b0);
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Buffered transmit controller between the CPU's memory-mapped UART data writes and corescore_emitter_uart.
- Accepts byte writes from the bus into a FIFO and sequences them into the emitter over its valid/ready handshake.
- Reports level, full and busy status, so firmware no longer spins on the emitter's ready bit for every byte.
- Sits in SOC: bus side on the IO page, emitter side driving i_data/i_valid and sampling o_ready.

Parameters:
- DEPTH, 16: FIFO entries. Must be a power of 2, at least 2.
- AW, 4: pointer width, log2(DEPTH).

Ports:
- i_clk  in  1  system clock (all logic on posedge).
- i_rst  in  1  synchronous, active-high reset.
- i_wr  in  1  bus write strobe to the data register (one byte per cycle).
- i_wdata  in  8  byte to enqueue.
- i_flush  in  1  discard all queued bytes.
- i_clr_ovf  in  1  clear the sticky overflow flag.
- o_data  out  8  byte presented to the emitter's i_data.
- o_valid  out  1  to the emitter's i_valid.
- i_ready  in  1  from the emitter's o_ready.
- o_level  out  AW+1  bytes queued, range 0..DEPTH; excludes the byte held in o_data.
- o_full  out  1  level == DEPTH.
- o_empty  out  1  level == 0.
- o_busy  out  1  !o_empty, or FSM not in IDLE, or !i_ready.
- o_overflow  out  1  sticky: a write was dropped.

Behaviour:
- Reset:
  - rd_ptr = wr_ptr = 0, level = 0, state = IDLE.
  - o_data = 0, o_valid = 0, o_overflow = 0.
  - o_empty = 1, o_full = 0.
  - Reset mid-transfer drops the held byte; o_valid is low on the next cycle.
- Pointers:
  - rd_ptr and wr_ptr are AW bits, wrap modulo DEPTH naturally.
  - level is a separate AW+1-bit counter: +1 on accepted write, -1 on pop, unchanged when both happen.
- Write:
  - Accepted when i_wr && !o_full, with o_full as registered at cycle start.
  - A write while full is dropped, even if a pop occurs the same cycle, and sets o_overflow.
- Overflow flag:
  - i_clr_ovf clears o_overflow.
  - If a set and i_clr_ovf occur in the same cycle, set wins.
- FSM states:
  - IDLE: if !o_empty, pop: o_data <= mem[rd_ptr], rd_ptr++, level--. Go to PRESENT.
  - PRESENT: o_valid = 1. When i_ready = 1 the handshake completes: go to GAP, o_valid drops next cycle. o_data is stable for the whole of PRESENT.
  - GAP: o_valid = 0 for exactly one cycle, ignoring i_ready, to cover the emitter's ready deassert latency. Then go to IDLE.
- Latency and throughput:
  - Write at cycle N into an empty, idle block: level = 1 at N+1, pop at N+1, o_valid = 1 at N+2.
  - Back-to-back bytes: at least 3 cycles per byte, plus the emitter's serialization time.
- Flush:
  - i_flush resets pointers and level to 0 in one cycle.
  - It does not retract a byte already in PRESENT; valid stays asserted until the handshake completes.
  - Flush and write in the same cycle: flush wins, the byte is dropped, o_overflow is unaffected.
  - Flush and pop in the same cycle: the pop completes (o_data loaded), then the FIFO is empty.
- o_valid is registered, never combinationally dependent on i_ready.
- Wrap-around: after 2*DEPTH writes and pops the data order is preserved, and full/empty are exact at every level.

Decomposition:
- Shared package:
  - FSM state localparams: IDLE = 0, PRESENT = 1, GAP = 2, with a 2-bit state type.
  - IO bit indices for the new data and status words, alongside the existing GPIO/UART bits.
- One sub-module, sync_fifo_byte: storage array, pointers, level counter, full/empty, flush.
- The top level holds the FSM, output register and overflow logic.

Test Plan:
- Single byte: reset, write 0x41 at cycle 10 with i_ready held at 1.
  - Required: o_valid = 1 at cycle 12 with o_data = 0x41.
  - Required: o_valid = 0 at cycle 13, o_busy = 0 by cycle 15.
- Fill to full:
  - Setup: i_ready = 0, write 0x00..0x10 on consecutive cycles (17 bytes).
  - Required: first byte moves to o_data; 16 remain queued (level = 16, o_full = 1); o_overflow = 0.
  - Stimulus: one more write.
  - Required: o_overflow = 1, level still 16.
- Ordered drain: from the full state, toggle i_ready in an emitter model.
  - Required: 17 handshakes in order 0x00..0x10, each o_valid pulse separated by at least 1 low cycle.
  - Required: o_empty = 1 at the end.
- Wrap-around: stream 40 bytes 0x80+k with random i_ready stalls.
  - Required: output sequence identical to input; level never exceeds 16; full/empty match a reference model.
- Flush:
  - Stimulus: queue 5 bytes with i_ready = 0, then assert i_flush together with i_wr(0x55).
  - Required: level = 0 next cycle; the held byte still completes on i_ready = 1; 0x55 never appears; o_overflow = 0.
- Reset mid-operation: assert i_rst while in PRESENT with level = 3.
  - Required: o_valid = 0, level = 0, o_overflow = 0 next cycle.
  - Required: a post-reset write of 0x33 emerges 2 cycles later.
